l2_tag_way_array: RTL and testbench

//  N-way set-associative tag store for the L2: per-way tag, valid, dirty, plus tree-PLRU per set.

---
 rtl/l2_tag_way_array_if.sv | 53 +++++
 rtl/l2_tag_way_array.sv | 186 ++++++++++++++++++
 tb/tb_l2_tag_way_array.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/l2_tag_way_array_if.sv
// l2_tag_way_array_if: lookup req/resp, line fill and invalidate bundle.
// master = L2 control side, slave = tag array.
interface l2_tag_way_array_if #(
  parameter int S_OFFSET = 5,
  parameter int S_INDEX  = 4,
  parameter int NUM_WAYS = 4,
  parameter int ADDR_W   = 32
);
  localparam int S_TAG = ADDR_W - S_OFFSET - S_INDEX;
  localparam int S_WAY = $clog2(NUM_WAYS);

  logic              lookup_valid;
  logic              lookup_ready;
  logic [ADDR_W-1:0] lookup_addr;
  logic              lookup_write;

  logic              resp_valid;
  logic              resp_hit;
  logic [S_WAY-1:0]  resp_way;
  logic [S_WAY-1:0]  resp_victim_way;
  logic              resp_victim_valid;
  logic              resp_victim_dirty;
  logic [S_TAG-1:0]  resp_victim_tag;

  logic              fill_valid;
  logic [S_INDEX-1:0] fill_index;
  logic [S_WAY-1:0]  fill_way;
  logic [S_TAG-1:0]  fill_tag;
  logic              fill_dirty;

  logic              inv_req;
  logic              inv_busy;

  modport master (
    output lookup_valid, lookup_addr, lookup_write,
    output fill_valid, fill_index, fill_way,
    output fill_tag, fill_dirty, inv_req,
    input  lookup_ready, resp_valid, resp_hit,
    input  resp_way, resp_victim_way,
    input  resp_victim_valid, resp_victim_dirty,
    input  resp_victim_tag, inv_busy
  );

  modport slave (
    input  lookup_valid, lookup_addr, lookup_write,
    input  fill_valid, fill_index, fill_way,
    input  fill_tag, fill_dirty, inv_req,
    output lookup_ready, resp_valid, resp_hit,
    output resp_way, resp_victim_way,
    output resp_victim_valid, resp_victim_dirty,
    output resp_victim_tag, inv_busy
  );
endinterface

// File: rtl/l2_tag_way_array.sv
// l2_tag_way_array: N-way L2 tag store, tree-PLRU, registered lookup.
// Ports: clk, reset_n (async low), bus (lookup/resp, fill, invalidate).
module l2_tag_way_array #(
  parameter int S_OFFSET = 5,
  parameter int S_INDEX  = 4,
  parameter int NUM_WAYS = 4,
  parameter int ADDR_W   = 32
) (
  input logic               clk,
  input logic               reset_n,
  l2_tag_way_array_if.slave bus
);
  localparam int NUM_SETS = 2 ** S_INDEX;
  localparam int S_TAG    = ADDR_W - S_OFFSET - S_INDEX;
  localparam int S_WAY    = $clog2(NUM_WAYS);
  localparam int NP       = NUM_WAYS - 1;

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t             state, state_nx;
  logic [S_INDEX-1:0] cnt, cnt_nx;
  logic               ready_en;

  logic [S_TAG-1:0]    tag_q  [NUM_SETS][NUM_WAYS];
  logic [NUM_WAYS-1:0] vld_q  [NUM_SETS];
  logic [NUM_WAYS-1:0] drt_q  [NUM_SETS];
  logic [NP-1:0]       plru_q [NUM_SETS];

  logic               r_valid, r_hit, r_vvalid, r_vdirty;
  logic [S_WAY-1:0]   r_way, r_vway;
  logic [S_TAG-1:0]   r_vtag;

  logic [S_INDEX-1:0] l_idx;
  logic [S_TAG-1:0]   l_tag;
  logic [NUM_WAYS-1:0] match;
  logic               hit, any_inv, acc, fill_ok;
  logic [S_WAY-1:0]   hit_way, inv_way, vic_way;
  logic               unused_off;

  // Heap-ordered tree: node for way w at level l is
  // (1<<l) + (w >> (S_WAY-l)), direction bit is way bit S_WAY-1-l.
  function automatic logic [S_WAY-1:0] plru_victim(
    input logic [NP-1:0] p
  );
    logic [S_WAY-1:0] v;
    logic ok;
    v = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      ok = 1'b1;
      for (int l = 0; l < S_WAY; l++)
        if (p[(1 << l) + (w >> (S_WAY - l)) - 1] !=
            1'((w >> (S_WAY - 1 - l)) & 1))
          ok = 1'b0;
      if (ok) v = S_WAY'(w);
    end
    return v;
  endfunction

  function automatic logic [NP-1:0] plru_touch(
    input logic [NP-1:0]    p,
    input logic [S_WAY-1:0] tw
  );
    logic [NP-1:0] r;
    r = p;
    for (int w = 0; w < NUM_WAYS; w++)
      if (tw == S_WAY'(w))
        for (int l = 0; l < S_WAY; l++)
          r[(1 << l) + (w >> (S_WAY - l)) - 1] =
            ~1'((w >> (S_WAY - 1 - l)) & 1);
    return r;
  endfunction

  assign l_idx = bus.lookup_addr[S_OFFSET +: S_INDEX];
  assign l_tag = bus.lookup_addr[ADDR_W-1 -: S_TAG];
  assign unused_off = ^bus.lookup_addr[S_OFFSET-1:0];

  assign bus.lookup_ready = ready_en && (state == IDLE) &&
                            !bus.fill_valid && !bus.inv_req;
  assign acc     = bus.lookup_valid && bus.lookup_ready;
  assign fill_ok = bus.fill_valid && (state == IDLE);
  assign hit     = |match;

  always_comb begin
    match   = '0;
    hit_way = '0;
    inv_way = '0;
    any_inv = 1'b0;
    for (int w = 0; w < NUM_WAYS; w++)
      match[w] = vld_q[l_idx][w] && (tag_q[l_idx][w] == l_tag);
    // Descending scan leaves the lowest invalid way selected.
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (match[w]) hit_way = S_WAY'(w);
      if (!vld_q[l_idx][w]) begin
        inv_way = S_WAY'(w);
        any_inv = 1'b1;
      end
    end
    vic_way = any_inv ? inv_way : plru_victim(plru_q[l_idx]);
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      IDLE: if (bus.inv_req) begin
        state_nx = SWEEP;
        cnt_nx   = '0;
      end
      SWEEP: begin
        cnt_nx = cnt + 1'b1;
        if (cnt == S_INDEX'(NUM_SETS - 1)) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      ready_en <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      ready_en <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        for (int w = 0; w < NUM_WAYS; w++) tag_q[s][w] <= '0;
        vld_q[s]  <= '0;
        drt_q[s]  <= '0;
        plru_q[s] <= '0;
      end
      r_valid  <= 1'b0;
      r_hit    <= 1'b0;
      r_way    <= '0;
      r_vway   <= '0;
      r_vvalid <= 1'b0;
      r_vdirty <= 1'b0;
      r_vtag   <= '0;
    end else begin
      r_valid <= acc;
      if (acc) begin
        r_hit    <= hit;
        r_way    <= hit_way;
        r_vway   <= vic_way;
        r_vvalid <= vld_q[l_idx][vic_way];
        r_vdirty <= drt_q[l_idx][vic_way];
        r_vtag   <= tag_q[l_idx][vic_way];
        if (hit) begin
          plru_q[l_idx] <= plru_touch(plru_q[l_idx], hit_way);
          if (bus.lookup_write) drt_q[l_idx][hit_way] <= 1'b1;
        end
      end
      if (fill_ok) begin
        tag_q[bus.fill_index][bus.fill_way] <= bus.fill_tag;
        vld_q[bus.fill_index][bus.fill_way] <= 1'b1;
        drt_q[bus.fill_index][bus.fill_way] <= bus.fill_dirty;
        plru_q[bus.fill_index] <=
          plru_touch(plru_q[bus.fill_index], bus.fill_way);
      end
      if (state == SWEEP) begin
        vld_q[cnt]  <= '0;
        drt_q[cnt]  <= '0;
        plru_q[cnt] <= '0;
      end
    end
  end

  assign bus.resp_valid        = r_valid;
  assign bus.resp_hit          = r_hit;
  assign bus.resp_way          = r_way;
  assign bus.resp_victim_way   = r_vway;
  assign bus.resp_victim_valid = r_vvalid;
  assign bus.resp_victim_dirty = r_vdirty;
  assign bus.resp_victim_tag   = r_vtag;
  assign bus.inv_busy          = (state == SWEEP);

  a_fill_in_sweep: assert property (@(posedge clk) disable iff (!reset_n)
    !(bus.fill_valid && state == SWEEP));
  a_dup_tag: assert property (@(posedge clk) disable iff (!reset_n)
    acc |-> $onehot0(match));
endmodule

// File: tb/tb_l2_tag_way_array.sv
// tb_l2_tag_way_array: directed + random check of l2_tag_way_array
// against a timestamp-based PLRU reference model.
module tb_l2_tag_way_array;
  localparam int NS = 16;
  localparam int NW = 4;

  logic clk;
  logic reset_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  l2_tag_way_array_if bus ();

  l2_tag_way_array dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state: tags, valid, dirty, last-touch time per way.
  int mtag [NS][NW];
  bit mvld [NS][NW];
  bit mdrt [NS][NW];
  int mts  [NS][NW];
  int now_t = 0;

  // Last observed response.
  bit r_hit, r_vvalid, r_vdirty;
  int r_way, r_vway, r_vtag;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model_clear(input bit tags);
    for (int s = 0; s < NS; s++)
      for (int w = 0; w < NW; w++) begin
        mvld[s][w] = 0;
        mdrt[s][w] = 0;
        mts[s][w]  = 0;
        if (tags) mtag[s][w] = 0;
      end
  endfunction

  function automatic void touch(input int s, input int w);
    now_t++;
    mts[s][w] = now_t;
  endfunction

  // Tree PLRU: at each split go to the half whose most recent
  // touch is older; untouched (both 0) goes to the lower half.
  function automatic int mvictim(input int s);
    int lo, size, half, mlo, mhi;
    for (int w = 0; w < NW; w++)
      if (!mvld[s][w]) return w;
    lo = 0;
    size = NW;
    while (size > 1) begin
      half = size / 2;
      mlo = 0;
      mhi = 0;
      for (int i = 0; i < half; i++) begin
        if (mts[s][lo+i] > mlo) mlo = mts[s][lo+i];
        if (mts[s][lo+half+i] > mhi) mhi = mts[s][lo+half+i];
      end
      if (mhi < mlo) lo = lo + half;
      size = half;
    end
    return lo;
  endfunction

  task automatic do_lookup(input int s, input int t, input bit wr,
                           input int off);
    bit hit;
    int hw, vw;
    hit = 0;
    hw  = 0;
    for (int w = 0; w < NW; w++)
      if (mvld[s][w] && mtag[s][w] == t) begin
        hit = 1;
        hw  = w;
      end
    vw = mvictim(s);
    bus.lookup_valid = 1'b1;
    bus.lookup_write = wr;
    bus.lookup_addr  = (32'(t) << 9) | (32'(s) << 5) | 32'(off);
    #1;
    chk("lookup_ready", 64'(bus.lookup_ready), 64'(1));
    @(posedge clk);
    #1;
    bus.lookup_valid = 1'b0;
    bus.lookup_write = 1'b0;
    r_hit    = bus.resp_hit;
    r_way    = int'(bus.resp_way);
    r_vway   = int'(bus.resp_victim_way);
    r_vvalid = bus.resp_victim_valid;
    r_vdirty = bus.resp_victim_dirty;
    r_vtag   = int'(bus.resp_victim_tag);
    chk("resp_valid", 64'(bus.resp_valid), 64'(1));
    chk("resp_hit", 64'(r_hit), 64'(hit));
    chk("resp_way", 64'(r_way), 64'(hw));
    chk("victim_way", 64'(r_vway), 64'(vw));
    chk("victim_valid", 64'(r_vvalid), 64'(mvld[s][vw]));
    chk("victim_dirty", 64'(r_vdirty), 64'(mdrt[s][vw]));
    chk("victim_tag", 64'(r_vtag), 64'(mtag[s][vw]));
    if (hit) begin
      touch(s, hw);
      if (wr) mdrt[s][hw] = 1;
    end
  endtask

  task automatic do_fill(input int s, input int w, input int t,
                         input bit d);
    bus.fill_valid = 1'b1;
    bus.fill_index = 4'(s);
    bus.fill_way   = 2'(w);
    bus.fill_tag   = 23'(t);
    bus.fill_dirty = d;
    #1;
    chk("ready_on_fill", 64'(bus.lookup_ready), 64'(0));
    @(posedge clk);
    #1;
    bus.fill_valid = 1'b0;
    mtag[s][w] = t;
    mvld[s][w] = 1;
    mdrt[s][w] = d;
    touch(s, w);
  endtask

  task automatic do_sweep();
    int n;
    bus.inv_req = 1'b1;
    @(posedge clk);
    #1;
    bus.inv_req = 1'b0;
    n = 0;
    while (bus.inv_busy && n < 100) begin
      if (n == 3) chk("ready_busy", 64'(bus.lookup_ready), 64'(0));
      bus.inv_req = (n == 5);
      @(posedge clk);
      #1;
      n++;
    end
    bus.inv_req = 1'b0;
    chk("sweep_len", 64'(n), 64'(NS));
    model_clear(0);
  endtask

  initial begin
    reset_n          = 1'b0;
    bus.lookup_valid = 1'b0;
    bus.lookup_addr  = '0;
    bus.lookup_write = 1'b0;
    bus.fill_valid   = 1'b0;
    bus.fill_index   = '0;
    bus.fill_way     = '0;
    bus.fill_tag     = '0;
    bus.fill_dirty   = 1'b0;
    bus.inv_req      = 1'b0;
    model_clear(1);

    #12;
    chk("rst_ready", 64'(bus.lookup_ready), 64'(0));
    chk("rst_resp_valid", 64'(bus.resp_valid), 64'(0));
    chk("rst_busy", 64'(bus.inv_busy), 64'(0));
    chk("rst_hit", 64'(bus.resp_hit), 64'(0));
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("ready_pre_edge", 64'(bus.lookup_ready), 64'(0));
    @(posedge clk);
    #1;

    // Post-reset lookup 0x1240: set 2, tag 9.
    do_lookup(2, 9, 0, 0);
    chk("pr_hit", 64'(r_hit), 64'(0));
    chk("pr_vway", 64'(r_vway), 64'(0));
    chk("pr_vvalid", 64'(r_vvalid), 64'(0));
    @(posedge clk);
    #1;
    chk("resp_one_cycle", 64'(bus.resp_valid), 64'(0));

    for (int w = 0; w < NW; w++) do_fill(2, w, 'h10 + w, 0);
    do_lookup(2, 'h12, 0, 3);
    chk("hit12", 64'(r_hit), 64'(1));
    chk("hit12_way", 64'(r_way), 64'(2));
    do_lookup(2, 'h55, 0, 0);
    chk("vic_after_hit", 64'(r_vway), 64'(0));

    do_lookup(2, 'h11, 1, 7);
    do_lookup(2, 'h10, 0, 0);
    do_lookup(2, 'h12, 0, 0);
    do_lookup(2, 'h13, 0, 0);
    do_lookup(2, 'h55, 0, 0);
    chk("dirty_vway", 64'(r_vway), 64'(1));
    chk("dirty_vdirty", 64'(r_vdirty), 64'(1));
    chk("dirty_vtag", 64'(r_vtag), 64'('h11));

    // Fill and lookup in the same cycle: fill wins.
    bus.lookup_valid = 1'b1;
    bus.lookup_addr  = (32'('h77) << 9) | (32'(5) << 5);
    do_fill(5, 3, 'h77, 1);
    chk("no_resp_on_fill", 64'(bus.resp_valid), 64'(0));
    do_lookup(5, 'h77, 0, 0);
    chk("fill_hit", 64'(r_hit), 64'(1));
    chk("fill_way", 64'(r_way), 64'(3));

    do_sweep();
    for (int s = 0; s < NS; s++) begin
      do_lookup(s, (s == 2) ? 'h12 : 'h77, 0, 0);
      chk("swept_miss", 64'(r_hit), 64'(0));
      chk("swept_vvalid", 64'(r_vvalid), 64'(0));
    end

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      int op, s, w, t;
      op = $urandom_range(0, 99);
      s  = $urandom_range(0, NS - 1);
      w  = $urandom_range(0, NW - 1);
      t  = $urandom_range(0, 7);
      if (op < 35) begin
        for (int w2 = 0; w2 < NW; w2++)
          if (w2 != w && mvld[s][w2] && mtag[s][w2] == t) w = w2;
        do_fill(s, w, t, 1'($urandom_range(0, 1)));
      end else if (op < 99) begin
        do_lookup(s, t, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 31));
      end else begin
        do_sweep();
      end
    end

    // Reset in the middle of a sweep.
    for (int w = 0; w < NW; w++) do_fill(9, w, 'h20 + w, 1);
    bus.inv_req = 1'b1;
    @(posedge clk);
    #1;
    bus.inv_req = 1'b0;
    repeat (7) begin
      @(posedge clk);
      #1;
    end
    chk("busy_mid", 64'(bus.inv_busy), 64'(1));
    reset_n = 1'b0;
    #1;
    chk("busy_rst", 64'(bus.inv_busy), 64'(0));
    chk("ready_rst", 64'(bus.lookup_ready), 64'(0));
    model_clear(1);
    now_t = 0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    for (int s = 0; s < NS; s++) begin
      do_lookup(s, (s == 9) ? 'h21 : 'h3, 0, 0);
      chk("rst_miss", 64'(r_hit), 64'(0));
      chk("rst_vvalid", 64'(r_vvalid), 64'(0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
